arm_dmem_responder: RTL and testbench

//  Responder on the CPU data-memory port (MemWrite, ALUResult as Addr, WriteData, ReadData).

---
 rtl/arm_dmem_responder_if.sv | 22 ++
 rtl/arm_dmem_responder.sv | 124 ++++++++++++
 tb/tb_arm_dmem_responder.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/arm_dmem_responder_if.sv
// CPU data-memory port plus TX byte stream, bundled for the dmem responder.
// The slave modport is the responder side; the master modport is the CPU/consumer side.
interface arm_dmem_responder_if;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  Led;
    logic [7:0]  TxData;
    logic        TxValid;
    logic        TxReady;

    modport slave (
        input  MemWrite, Addr, WriteData, TxReady,
        output ReadData, Led, TxData, TxValid
    );

    modport master (
        output MemWrite, Addr, WriteData, TxReady,
        input  ReadData, Led, TxData, TxValid
    );
endinterface

// File: rtl/arm_dmem_responder.sv
// Data-memory responder for a single-cycle core: word RAM plus an IO page with
// LED register, free-running cycle counter and a byte TX FIFO drained by valid/ready.
module arm_dmem_responder #(
    parameter int          MEM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE    = 32'h0000_8000
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    arm_dmem_responder_if.slave   bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [7:0] OFF_LED    = 8'h00;
    localparam logic [7:0] OFF_CYCLE  = 8'h04;
    localparam logic [7:0] OFF_TXDATA = 8'h08;
    localparam logic [7:0] OFF_STATUS = 8'h0C;

    logic [31:0]   ram_mem  [MEM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic [7:0]    led_q, led_d;
    logic [31:0]   cycle_q, cycle_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          io_sel, ram_sel;
    logic [7:0]    io_off;
    logic [AW-1:0] ram_idx;
    logic          io_wr, ram_we;
    logic          fifo_full, fifo_empty;
    logic          push_req, push, pop;
    logic [31:0]   status_word;
    logic [31:0]   read_data;
    logic          unused_addr_bits;

    assign io_sel   = (bus.Addr[31:8] == IO_BASE[31:8]);
    assign ram_sel  = !io_sel && (bus.Addr[31:2] < 30'(MEM_WORDS));
    assign io_off   = bus.Addr[7:0];
    assign ram_idx  = bus.Addr[2+AW-1:2];
    assign io_wr    = bus.MemWrite && io_sel;
    assign ram_we   = bus.MemWrite && ram_sel;
    assign unused_addr_bits = ^bus.Addr[1:0];

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    // Pop depends only on registered state and TxReady, so TxValid/TxData stay flop-driven.
    assign pop        = !fifo_empty && bus.TxReady;
    assign push_req   = io_wr && (io_off == OFF_TXDATA);
    assign push       = push_req && (!fifo_full || pop);

    assign status_word = {16'b0, 8'(count_q), 5'b0, ovf_q, fifo_empty, fifo_full};

    always_comb begin
        led_d    = led_q;
        cycle_d  = cycle_q + 32'd1;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;

        if (io_wr && io_off == OFF_LED)   led_d   = bus.WriteData[7:0];
        if (io_wr && io_off == OFF_CYCLE) cycle_d = '0;

        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        // Clear first so a simultaneous overflow leaves the flag set.
        if (io_wr && io_off == OFF_STATUS && bus.WriteData[2]) ovf_d = 1'b0;
        if (push_req && fifo_full && !pop)                     ovf_d = 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            led_q    <= '0;
            cycle_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            led_q    <= led_d;
            cycle_q  <= cycle_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage arrays carry no reset; their contents are only meaningful once written.
    always_ff @(posedge Clk) begin
        if (ram_we) ram_mem[ram_idx] <= bus.WriteData;
    end

    always_ff @(posedge Clk) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.WriteData[7:0];
    end

    always_comb begin
        read_data = '0;
        if (io_sel) begin
            case (io_off)
                OFF_LED:    read_data = {24'b0, led_q};
                OFF_CYCLE:  read_data = cycle_q;
                OFF_STATUS: read_data = status_word;
                default:    read_data = '0;
            endcase
        end else if (ram_sel) begin
            read_data = ram_mem[ram_idx];
        end
    end

    assign bus.ReadData = read_data;
    assign bus.Led      = led_q;
    assign bus.TxData   = fifo_mem[rd_ptr_q];
    assign bus.TxValid  = !fifo_empty;
endmodule

// File: tb/tb_arm_dmem_responder.sv
// Bench for arm_dmem_responder: directed register/RAM checks plus a byte
// scoreboard that is filled on accepted pushes and drained on observed pops.
module tb_arm_dmem_responder;
    logic Clk;
    logic Rst_n;
    int   n_checks;
    int   n_fail;
    logic [7:0] sb_q [$];

    arm_dmem_responder_if bus ();

    arm_dmem_responder #(
        .MEM_WORDS (64),
        .FIFO_DEPTH(8),
        .IO_BASE   (32'h0000_8000)
    ) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.Addr      = a;
        bus.WriteData = d;
        bus.MemWrite  = 1'b1;
        step();
        bus.MemWrite  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.Addr = a;
        #1;
        check_val(tag, bus.ReadData, exp);
    endtask

    task automatic drain(input string tag);
        bus.TxReady = 1'b1;
        for (int i = 0; i < 30 && bus.TxValid; i++) step();
        bus.TxReady = 1'b0;
        check_val({tag, "_done"}, {31'b0, bus.TxValid}, 32'd0);
        check_val({tag, "_sb_empty"}, sb_q.size(), 32'd0);
    endtask

    // Inputs are stable between posedge+1 and the next posedge, so a
    // handshake seen at the negedge is the pop that the next edge performs.
    always @(negedge Clk) begin
        if (Rst_n && bus.TxValid && bus.TxReady) begin
            if (sb_q.size() == 0) check_val("tx_extra", {24'b0, bus.TxData}, 32'h100);
            else                  check_val("tx_data", {24'b0, bus.TxData}, {24'b0, sb_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        Rst_n         = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.Addr      = '0;
        bus.WriteData = '0;
        bus.TxReady   = 1'b0;
        #1 Rst_n = 1'b0;
        #1;
        check_val("rst_led", {24'b0, bus.Led}, 32'd0);
        check_val("rst_txvalid", {31'b0, bus.TxValid}, 32'd0);
        rd_chk("rst_status", 32'h800C, 32'h0000_0002);

        // Reset release and first-edge counter value
        repeat (2) @(posedge Clk);
        #1 Rst_n = 1'b1;
        step();
        rd_chk("cycle_first", 32'h8004, 32'd1);
        rd_chk("status_idle", 32'h800C, 32'h0000_0002);

        // LED register
        wr(32'h8000, 32'h0000_01A5);
        check_val("led_out", {24'b0, bus.Led}, 32'h0000_00A5);
        rd_chk("led_read", 32'h8000, 32'h0000_00A5);
        rd_chk("txdata_read", 32'h8008, 32'd0);
        rd_chk("io_other", 32'h8010, 32'd0);

        // RAM, including the top word and the first unmapped word
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd_chk("ram_0x10", 32'h0000_0010, 32'hDEAD_BEEF);
        rd_chk("ram_0x13", 32'h0000_0013, 32'hDEAD_BEEF);
        rd_chk("unmapped_rd", 32'h0000_4000, 32'd0);
        wr(32'h0000_0014, 32'h1234_5678);
        rd_chk("ram_0x14", 32'h0000_0014, 32'h1234_5678);
        rd_chk("ram_0x10_kept", 32'h0000_0010, 32'hDEAD_BEEF);
        wr(32'h0000_0000, 32'h1111_1111);
        wr(32'h0000_00FC, 32'h5555_AAAA);
        wr(32'h0000_0100, 32'hCAFE_F00D);
        rd_chk("ram_top", 32'h0000_00FC, 32'h5555_AAAA);
        rd_chk("ram_no_alias", 32'h0000_0000, 32'h1111_1111);
        rd_chk("unmapped_0x100", 32'h0000_0100, 32'd0);

        // FIFO fill, overflow, ovf clear, in-order drain
        for (int i = 0; i < 8; i++) begin
            wr(32'h8008, 32'(8'h41 + i));
            sb_q.push_back(8'(8'h41 + i));
        end
        rd_chk("status_full", 32'h800C, 32'h0000_0801);
        wr(32'h8008, 32'h0000_0049);
        rd_chk("status_ovf", 32'h800C, 32'h0000_0805);
        check_val("head_byte", {24'b0, bus.TxData}, 32'h0000_0041);
        wr(32'h800C, 32'h0000_0004);
        rd_chk("ovf_cleared", 32'h800C, 32'h0000_0801);
        drain("drain1");
        rd_chk("status_after_drain", 32'h800C, 32'h0000_0002);

        // Push and pop on the same edge while full
        for (int i = 0; i < 8; i++) begin
            wr(32'h8008, 32'(8'h61 + i));
            sb_q.push_back(8'(8'h61 + i));
        end
        bus.TxReady   = 1'b1;
        bus.Addr      = 32'h8008;
        bus.WriteData = 32'h0000_005A;
        bus.MemWrite  = 1'b1;
        sb_q.push_back(8'h5A);
        step();
        bus.MemWrite  = 1'b0;
        bus.TxReady   = 1'b0;
        rd_chk("full_pushpop", 32'h800C, 32'h0000_0801);
        drain("drain2");

        // Cycle counter clear and count
        wr(32'h8004, 32'hFFFF_FFFF);
        rd_chk("cycle_clear", 32'h8004, 32'd0);
        repeat (5) step();
        rd_chk("cycle_plus5", 32'h8004, 32'd5);

        // Asynchronous reset between edges with bytes queued
        for (int i = 0; i < 4; i++) begin
            wr(32'h8008, 32'(8'hB0 + i));
            sb_q.push_back(8'(8'hB0 + i));
        end
        rd_chk("status_four", 32'h800C, 32'h0000_0400);
        #1 Rst_n = 1'b0;
        #1;
        check_val("arst_txvalid", {31'b0, bus.TxValid}, 32'd0);
        check_val("arst_led", {24'b0, bus.Led}, 32'd0);
        rd_chk("arst_status", 32'h800C, 32'h0000_0002);
        rd_chk("arst_cycle", 32'h8004, 32'd0);
        sb_q.delete();
        step();
        Rst_n = 1'b1;
        step();
        rd_chk("cycle_resume", 32'h8004, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
